pwm_cfg_arbiter: RTL
====================

PWM_CFG_ARBITER -- requirements
Module: pwm_cfg_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing one PWM channel config port.
REQ-002 Parameter TIMEOUT, default 16, idle-beat cycles before a stalled burst is revoked.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester beat valid.
REQ-006 req_addr  input  2*NUM_REQ  per-requester target: 0=control, 1=period, 2=duty, 3=invalid.
REQ-007 req_data  input  32*NUM_REQ  per-requester write data.
REQ-008 req_last  input  NUM_REQ  marks final beat of a burst.
REQ-009 req_ready  output  NUM_REQ  beat accepted when valid&ready.
REQ-010 control_out  output  3  to channel control_in.
REQ-011 period_out  output  32  to channel period_in.
REQ-012 duty_out  output  32  to channel duty_in.
REQ-013 cont_wen, period_wen, duty_wen  output  1 each  one-cycle write strobes.
REQ-014 grant_id  output  clog2(NUM_REQ)  current owner; valid only while busy.
REQ-015 busy  output  1  high in BURST state.
REQ-016 err_pulse  output  1  one-cycle pulse on invalid address or timeout.

Function
REQ-017 FSM shall have two states, IDLE and BURST.
REQ-018 In IDLE, req_ready shall be all-zero; if any req_valid is high, the arbiter shall select a winner round-robin, starting search at (last_owner+1) mod NUM_REQ, latch it in grant_id and enter BURST next cycle; winner selection costs exactly one cycle.
REQ-019 In BURST, req_ready shall be high only for grant_id; all other requesters stall.
REQ-020 Each accepted beat shall produce, on the following cycle, exactly one strobe: addr 0 -> cont_wen with control_out=data[2:0]; addr 1 -> period_wen with period_out=data; addr 2 -> duty_wen with duty_out=data.
REQ-021 Addr 3 beats shall be accepted and dropped: no strobe, err_pulse high on the following cycle.
REQ-022 control_out, period_out, duty_out shall hold last written value between strobes; at most one wen high in any cycle.
REQ-023 Accepted beat with req_last=1 shall return FSM to IDLE next cycle and update last_owner to grant_id; back-to-back bursts thus have one idle arbitration cycle.
REQ-024 In BURST, a timeout counter shall count consecutive cycles with owner's req_valid low; reset to 0 on any accepted beat; on reaching TIMEOUT, FSM returns to IDLE, last_owner updates, err_pulse pulses one cycle, no strobe.
REQ-025 Requester dropping req_valid mid-burst shall not lose ownership before timeout.
REQ-026 Simultaneous accepted invalid-addr last beat: err_pulse and return to IDLE both occur.

Reset
REQ-027 On rst high at a clock edge: FSM=IDLE, req_ready=0, all wen=0, control_out=0, period_out=0, duty_out=0, grant_id=0, busy=0, err_pulse=0, timeout counter=0, last_owner=NUM_REQ-1 (so requester 0 wins first).
REQ-028 rst asserted mid-burst shall abort the burst; any beat accepted in that cycle shall produce no strobe.

Structure
REQ-029 Shared package pwm_pkg shall hold ADDR_CTRL=0, ADDR_PERIOD=1, ADDR_DUTY=2, ADDR_INV=3 and the FSM state enum.
REQ-030 One sub-module pwm_rr_select (combinational round-robin pick from valid vector and last_owner) shall be used; timeout counter inline, because flex_counter uses an asynchronous active-low reset and is not reused here.

Verification
REQ-031 Reset then req0 single beat addr1 data 1000 last=1 -> grant cycle, ready0 next, period_wen with period_out=1000 one cycle after accept, busy drops.
REQ-032 req0 and req1 valid same cycle after reset -> req0 granted first, req1 granted after req0 last beat plus one idle cycle; then both again -> req0 wins (rotation).
REQ-033 req1 burst addr0 data 3'b101, addr2 data 250 last -> cont_wen control_out=5, then duty_wen duty_out=250, consecutive cycles.
REQ-034 req0 beat addr3 data 0xFFFF_FFFF -> no wen, err_pulse one cycle, outputs unchanged.
REQ-035 req0 sends one non-last beat then drops valid for 16 cycles -> FSM IDLE, err_pulse once, req1 pending then granted.
REQ-036 rst high in cycle req0 beat accepted mid-burst -> no strobe next cycle, all outputs at reset values.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and FSM state type for the PWM channel config arbiter.
package pwm_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_DUTY   = 2'd2;
  localparam logic [1:0] ADDR_INV    = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/pwm_cfg_arbiter_if.sv
// Request bus shared by all requesters of one PWM channel config port.
interface pwm_cfg_arbiter_if #(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [2*NUM_REQ-1:0]  req_addr;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ-1:0]    req_ready;

  modport master (
    output req_valid, req_addr, req_data, req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_last,
    output req_ready
  );

endinterface

// File: rtl/pwm_rr_select.sv
// Combinational round-robin pick: the first valid requester after last_owner wins.
module pwm_rr_select #(
  parameter int NUM_REQ = 2,
  parameter int GW      = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [GW-1:0]      last_owner,
  output logic [GW-1:0]      winner,
  output logic               any_valid
);

  // Walk offsets from farthest to nearest so the nearest valid requester is assigned last.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (valid[j] && (j == ((int'(last_owner) + off) % NUM_REQ))) begin
          winner    = GW'(j);
          any_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_cfg_arbiter.sv
// Arbitrates NUM_REQ requesters onto one PWM channel config port, one burst at a time.
// Each beat accepted from the owner becomes a single-cycle write strobe on the next cycle.
module pwm_cfg_arbiter
  import pwm_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int TIMEOUT = 16,
  localparam int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  pwm_cfg_arbiter_if.slave req_bus,
  output logic [2:0]    control_out,
  output logic [31:0]   period_out,
  output logic [31:0]   duty_out,
  output logic          cont_wen,
  output logic          period_wen,
  output logic          duty_wen,
  output logic [GW-1:0] grant_id,
  output logic          busy,
  output logic          err_pulse
);

  state_t             state;
  state_t             state_next;
  logic [GW-1:0]      last_owner;
  logic [GW-1:0]      winner;
  logic               any_valid;
  logic [CW-1:0]      idle_cnt;
  logic [NUM_REQ-1:0] ready_vec;
  logic               owner_valid;
  logic               owner_last;
  logic [1:0]         owner_addr;
  logic [31:0]        owner_data;
  logic               accept;
  logic               timeout_hit;

  pwm_rr_select #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_rr_select (
    .valid      (req_bus.req_valid),
    .last_owner (last_owner),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_addr  = '0;
    owner_data  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (GW'(j) == grant_id) begin
        owner_valid = req_bus.req_valid[j];
        owner_last  = req_bus.req_last[j];
        owner_addr  = req_bus.req_addr[2*j +: 2];
        owner_data  = req_bus.req_data[32*j +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The owner's ready is unconditional in BURST, so a valid beat from it is always accepted.
  always_comb begin
    state_next  = state;
    ready_vec   = '0;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_next = BURST;
        end
      end
      BURST: begin
        for (int j = 0; j < NUM_REQ; j++) begin
          ready_vec[j] = (GW'(j) == grant_id);
        end
        accept      = owner_valid;
        timeout_hit = !owner_valid && (idle_cnt == CW'(TIMEOUT - 1));
        if ((accept && owner_last) || timeout_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_bus.req_ready = ready_vec;
  assign busy              = (state == BURST);

  // Reset aborts any beat accepted in the same cycle, so no strobe ever follows a reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      control_out <= '0;
      period_out  <= '0;
      duty_out    <= '0;
      cont_wen    <= 1'b0;
      period_wen  <= 1'b0;
      duty_wen    <= 1'b0;
      err_pulse   <= 1'b0;
      grant_id    <= '0;
      idle_cnt    <= '0;
      last_owner  <= GW'(NUM_REQ - 1);
    end else begin
      cont_wen   <= 1'b0;
      period_wen <= 1'b0;
      duty_wen   <= 1'b0;
      err_pulse  <= 1'b0;
      if (state == IDLE) begin
        idle_cnt <= '0;
        if (any_valid) begin
          grant_id <= winner;
        end
      end else if (accept) begin
        idle_cnt <= '0;
        case (owner_addr)
          ADDR_CTRL: begin
            cont_wen    <= 1'b1;
            control_out <= owner_data[2:0];
          end
          ADDR_PERIOD: begin
            period_wen <= 1'b1;
            period_out <= owner_data;
          end
          ADDR_DUTY: begin
            duty_wen <= 1'b1;
            duty_out <= owner_data;
          end
          default: err_pulse <= 1'b1;
        endcase
        if (owner_last) begin
          last_owner <= grant_id;
        end
      end else if (timeout_hit) begin
        idle_cnt   <= '0;
        err_pulse  <= 1'b1;
        last_owner <= grant_id;
      end else begin
        idle_cnt <= idle_cnt + CW'(1);
      end
    end
  end

endmodule
